// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm arbiter: FSM state encoding and the
// table of product-term codes (XYZKM) that the decoder recognises.
package minterm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_TERMS = 14;

  // Entry t holds the code of term number t+1.
  localparam logic [4:0] TERM_CODE [NUM_TERMS] = '{
    5'h02, 5'h03, 5'h0A, 5'h0B, 5'h0F, 5'h06, 5'h04,
    5'h15, 5'h14, 5'h11, 5'h13, 5'h1B, 5'h19, 5'h12
  };

endpackage

// File: rtl/minterm_decode.sv
// Combinational product-term decoder: reports whether a 5-bit XYZKM word
// matches a term and which term number (1..14) it is; 0 when no match.
module minterm_decode
  import minterm_pkg::*;
(
  input  logic [4:0] i_word,
  output logic       o_hit,
  output logic [3:0] o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      if (i_word == TERM_CODE[t]) begin
        o_hit = 1'b1;
        o_idx = 4'(t + 1);
      end
    end
  end

endmodule

// File: rtl/minterm_arb_ctrl.sv
// Round-robin arbiter sharing one minterm decoder among NREQ requesters,
// with a registered grant, one-cycle response pulse and saturating hit counters.
module minterm_arb_ctrl
  import minterm_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [5*NREQ-1:0]        word_in,
  output logic [NREQ-1:0]          ack,
  output logic                     res_valid,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_hit,
  output logic [3:0]               res_idx,
  input  logic [$clog2(NREQ)-1:0]  cnt_sel,
  output logic [CNT_W-1:0]         cnt_out,
  input  logic                     cnt_clr
);

  localparam int ID_W = $clog2(NREQ);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_gnt;
  logic [4:0]        r_word;
  logic [CNT_W-1:0]  r_cnt [NREQ];

  logic [NREQ-1:0]   w_reqAvail;
  logic              w_gntFound;
  logic [ID_W-1:0]   w_gntIdx;
  logic [4:0]        w_gntWord;
  logic              w_grant;
  logic              w_resp;
  logic              w_hit;
  logic [3:0]        w_idx;

  minterm_decode u_decode (
    .i_word (r_word),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Outputs are suppressed while reset is held so an aborted response never acks.
  assign w_resp     = (r_state == RESP) && rst_n;
  assign w_reqAvail = req & ~ack;

  always_comb begin
    ack          = '0;
    res_valid    = w_resp;
    res_id       = '0;
    res_hit      = 1'b0;
    res_idx      = '0;
    if (w_resp) begin
      ack[r_gnt] = 1'b1;
      res_id     = r_gnt;
      res_hit    = w_hit;
      res_idx    = w_idx;
    end
  end

  // First available request at or above the pointer, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    w_gntFound = 1'b0;
    w_gntIdx   = '0;
    w_gntWord  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_gntFound && w_reqAvail[j]) begin
        w_gntFound = 1'b1;
        w_gntIdx   = ID_W'(j);
        w_gntWord  = word_in[5*j +: 5];
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: if (w_gntFound) begin
        w_stateNext = EVAL;
        w_grant     = 1'b1;
      end
      EVAL: w_stateNext = RESP;
      RESP: begin
        w_stateNext = w_gntFound ? EVAL : IDLE;
        w_grant     = w_gntFound;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_grant) begin
        r_gnt  <= w_gntIdx;
        r_word <= w_gntWord;
        r_ptr  <= (int'(w_gntIdx) == NREQ - 1) ? '0 : w_gntIdx + 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else if (res_hit && (r_cnt[r_gnt] != '1)) begin
      r_cnt[r_gnt] <= r_cnt[r_gnt] + CNT_W'(1);
    end
  end

  assign cnt_out = r_cnt[cnt_sel];

endmodule

// File: tb/tb_minterm_arb_ctrl.sv
// Scoreboard bench for minterm_arb_ctrl: expected results are queued when
// requests are driven and compared when the arbiter responds.
module tb_minterm_arb_ctrl;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = $clog2(NREQ);

  typedef struct {
    int id;
    int hit;
    int idx;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [5*NREQ-1:0]  word_in;
  logic [NREQ-1:0]    ack;
  logic               res_valid;
  logic [ID_W-1:0]    res_id;
  logic               res_hit;
  logic [3:0]         res_idx;
  logic [ID_W-1:0]    cnt_sel;
  logic [CNT_W-1:0]   cnt_out;
  logic               cnt_clr;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   popCount    = 0;

  minterm_arb_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .word_in   (word_in),
    .ack       (ack),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_hit   (res_hit),
    .res_idx   (res_idx),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference term numbering, written independently of the design table.
  function automatic int refIdx(input logic [4:0] w);
    case (w)
      5'h02: return 1;
      5'h03: return 2;
      5'h0A: return 3;
      5'h0B: return 4;
      5'h0F: return 5;
      5'h06: return 6;
      5'h04: return 7;
      5'h15: return 8;
      5'h14: return 9;
      5'h11: return 10;
      5'h13: return 11;
      5'h1B: return 12;
      5'h19: return 13;
      5'h12: return 14;
      default: return 0;
    endcase
  endfunction

  task automatic pushExp(input int id, input logic [4:0] w);
    exp_t e;
    e.id  = id;
    e.idx = refIdx(w);
    e.hit = (e.idx != 0) ? 1 : 0;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [5*NREQ-1:0] w);
    req     = r;
    word_in = w;
  endtask

  task automatic waitResults(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (popCount < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, popCount, target);
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, res_valid, 1);
  endtask

  task automatic checkCounter(input string tag, input int sel, input int expected);
    cnt_sel = ID_W'(sel);
    #1;
    checkOutput(tag, cnt_out, expected);
  endtask

  task automatic pulseClear();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    req     = '0;
    cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: pop and compare on every valid response, idle outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", {28'd0, res_id, res_idx}, 32'hFFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("res_id", res_id, e.id);
        checkOutput("ack", ack, 1 << e.id);
        checkOutput("res_hit", res_hit, e.hit);
        checkOutput("res_idx", res_idx, e.idx);
      end
      popCount++;
    end else begin
      checkOutput("idle_outputs", {ack, res_id, res_hit, res_idx}, 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int expSat;
    int hits;
    rst_n   = 1'b0;
    req     = '0;
    word_in = '0;
    cnt_sel = '0;
    cnt_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outputs", {ack, res_valid, res_id, res_hit, res_idx}, 0);
    for (int i = 0; i < NREQ; i++) checkCounter("rst_counter", i, 0);
    rst_n = 1'b1;

    // Single request with exact latency
    base = popCount;
    pushExp(0, 5'h0F);
    applyStimulus(4'b0001, {15'd0, 5'h0F});
    @(posedge clk); #1;
    checkOutput("lat_eval_quiet", {ack, res_valid}, 0);
    @(posedge clk); #1;
    checkOutput("lat_resp_ack", ack, 4'b0001);
    waitResults("single_done", base + 1, 10);
    req = '0;
    checkCounter("single_counter0", 0, 1);

    // Round robin over four held requests, wrapping back to 0
    doReset();
    base = popCount;
    pushExp(0, 5'h02); pushExp(1, 5'h04); pushExp(2, 5'h1B);
    pushExp(3, 5'h1F); pushExp(0, 5'h02); pushExp(1, 5'h04);
    applyStimulus(4'b1111, {5'h1F, 5'h1B, 5'h04, 5'h02});
    waitResults("rr_first_round", base + 4, 40);
    checkCounter("rr_cnt0", 0, 1);
    checkCounter("rr_cnt1", 1, 1);
    checkCounter("rr_cnt2", 2, 1);
    checkCounter("rr_cnt3", 3, 0);
    waitResults("rr_wrap", base + 5, 20);
    req = '0;
    waitResults("rr_withdrawn_after_grant", base + 6, 20);
    checkCounter("rr_end_cnt0", 0, 2);
    checkCounter("rr_end_cnt1", 1, 2);
    repeat (3) @(posedge clk);
    #1;

    // Every code on requester 0
    pulseClear();
    hits = 0;
    for (int code = 0; code < 32; code++) begin
      base = popCount;
      pushExp(0, 5'(code));
      if (refIdx(5'(code)) != 0) hits++;
      applyStimulus(4'b0001, {15'd0, 5'(code)});
      waitResults("code_sweep", base + 1, 10);
      req = '0;
    end
    checkCounter("sweep_hits", 0, 14);

    // Saturation of requester 2
    pulseClear();
    base = popCount;
    expSat = 0;
    for (int n = 0; n < 300; n++) begin
      pushExp(2, 5'h1B);
      if (expSat != 255) expSat++;
    end
    applyStimulus(4'b0100, {5'd0, 5'h1B, 10'd0});
    waitResults("sat_done", base + 300, 1000);
    req = '0;
    checkCounter("sat_counter2", 2, expSat);

    // Clear on the same edge as an increment
    @(posedge clk); #1;
    base = popCount;
    pushExp(2, 5'h1B);
    applyStimulus(4'b0100, {5'd0, 5'h1B, 10'd0});
    waitValid("clr_resp_seen", 10);
    cnt_clr = 1'b1;
    waitResults("clr_done", base + 1, 10);
    cnt_clr = 1'b0;
    req = '0;
    checkCounter("clr_counter2", 2, 0);

    // Reset during the response cycle
    @(posedge clk); #1;
    applyStimulus(4'b0001, {15'd0, 5'h0F});
    waitValid("abort_resp_seen", 10);
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("abort_no_ack", {ack, res_valid}, 0);
    @(posedge clk); #1;
    checkOutput("abort_outputs", {ack, res_valid, res_id, res_hit, res_idx}, 0);
    checkCounter("abort_counter0", 0, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_idle", {ack, res_valid}, 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/minterm_arb_ctrl.md
MINTERM_ARB_CTRL -- requirements
Module: minterm_arb_ctrl

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing the minterm decoder.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of each per-requester hit counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, NREQ bits: request per requester, held high until acked.
REQ-006 The block SHALL have port word_in, input, 5*NREQ bits: requester i word at bits [5i+4:5i], order X,Y,Z,K,M with X as MSB.
REQ-007 The block SHALL have port ack, output, NREQ bits: one-hot, one-cycle pulse to the served requester.
REQ-008 The block SHALL have port res_valid, output, 1 bit: result fields valid this cycle.
REQ-009 The block SHALL have port res_id, output, clog2(NREQ) bits: index of the served requester.
REQ-010 The block SHALL have port res_hit, output, 1 bit: served word matched a product term.
REQ-011 The block SHALL have port res_idx, output, 4 bits: matched term number 1..14; 0 when no match.
REQ-012 The block SHALL have port cnt_sel, input, clog2(NREQ) bits: selects the hit counter to read.
REQ-013 The block SHALL have port cnt_out, output, CNT_W bits: combinational read of the selected hit counter.
REQ-014 The block SHALL have port cnt_clr, input, 1 bit: clears all hit counters on the next edge.

Function
REQ-015 Term table (XYZKM, hex): 1=02, 2=03, 3=0A, 4=0B, 5=0F, 6=06, 7=04, 8=15, 9=14, 10=11, 11=13, 12=1B, 13=19, 14=12; all other codes are no match.
REQ-016 FSM states SHALL be IDLE, EVAL, RESP; IDLE->EVAL when any req is high; EVAL->RESP unconditionally; RESP->EVAL if any req not being acked is high, else RESP->IDLE.
REQ-017 In the cycle of entry to EVAL, the arbiter SHALL grant round-robin: the first high req at or after ptr, searched upward with wrap-around; the granted word is registered.
REQ-018 In RESP, ack[g], res_valid, res_id=g, and res_hit/res_idx from the registered word SHALL be driven for exactly one cycle; latency from grant to result is 2 cycles.
REQ-019 After each grant, ptr SHALL become g+1 mod NREQ; ptr only advances on a grant.
REQ-020 A req withdrawn before grant SHALL be ignored; a req withdrawn after grant SHALL still receive its ack and result.
REQ-021 On res_valid with res_hit=1, counter[res_id] SHALL increment, saturating at all-ones.
REQ-022 cnt_clr SHALL take priority over a simultaneous increment; the counter reads 0 afterwards.
REQ-023 When not in RESP, ack SHALL be 0, res_valid SHALL be 0, and res_id/res_hit/res_idx SHALL be 0.

Reset
REQ-024 With rst_n low at a rising edge, the state SHALL be IDLE, ptr 0, all counters 0, the registered word 0, and all outputs 0 on the following cycle.
REQ-025 A reset asserted in EVAL or RESP SHALL abort the transaction with no ack and no counter update; requesters re-request.

Structure
REQ-026 The term codes and their numbers (REQ-015) and the FSM state encoding SHALL live in shared package minterm_pkg.
REQ-027 The decode of REQ-015 SHALL be a combinational sub-module minterm_decode (5-bit in; hit and 4-bit idx out), instantiated once.

Verification
REQ-028 Reset then req=0001, word0=0F -> 2 cycles later ack=0001, res_hit=1, res_idx=5, res_id=0, counter0=1.
REQ-029 req=1111 held, words 02,04,1B,1F -> acks in order 0,1,2,3 with idx 1,7,12,0; then wrap to 0; counters 1,1,1,0 after the first round.
REQ-030 Requester 2 hits 300 times with CNT_W=8 -> counter2 saturates at 255; cnt_clr asserted on an increment cycle -> 0.
REQ-031 All 32 codes on requester 0 -> exactly 14 hits with indices per REQ-015; the other 18 codes give res_hit=0 and idx=0.
REQ-032 rst_n low in the RESP cycle -> no ack and no counter change; IDLE and outputs 0 next cycle.
